// File: rtl/tone_pkg.sv
// tone_pkg: shared scale constants, enums and helpers for the buzzer tone generator and decoder
package tone_pkg;
   localparam int NUM_NOTES = 8;
   // generator divider values: mid do, re, mi, fa, so, la, ti, high do
   localparam logic [19:0] DIV_TBL [NUM_NOTES] = '{
      20'd47774, 20'd42568, 20'd37919, 20'd35791,
      20'd31888, 20'd28409, 20'd25309, 20'd23889
   };
   typedef enum logic [3:0] {
      NOTE_DO_M, NOTE_RE_M, NOTE_MI_M, NOTE_FA_M,
      NOTE_SO_M, NOTE_LA_M, NOTE_TI_M, NOTE_DO_H, NOTE_NONE
   } note_e;
   typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_e;
   // the generator toggles its output every divider+1 cycles
   function automatic logic [19:0] half_period(input logic [2:0] idx);
      return DIV_TBL[idx] + 20'd1;
   endfunction
   function automatic logic [7:0] note_onehot(input note_e n);
      return (n == NOTE_NONE) ? 8'd0 : 8'd1 << n;
   endfunction
endpackage

// File: rtl/tone_decoder_if.sv
// tone_decoder_if: tone input and detected-note outputs of the tone decoder
//   TONE_IN  : square-wave tone line into the decoder
//   NOTE     : one-hot detected note, bit0 = mid do .. bit7 = high do, 0 = none
//   VALID    : high while locked
//   NOTE_STB : one-cycle pulse when NOTE takes a new non-zero value
//   master = decoder side, slave = consumer / stimulus side
interface tone_decoder_if;
   logic       TONE_IN;
   logic [7:0] NOTE;
   logic       VALID;
   logic       NOTE_STB;
   modport master (input TONE_IN, output NOTE, VALID, NOTE_STB);
   modport slave (output TONE_IN, input NOTE, VALID, NOTE_STB);
endinterface

// File: rtl/tone_edge_sync.sv
// tone_edge_sync: 2-FF synchroniser plus delay flop; pulses on both tone polarities
//   CLK_50M, RST : clock, synchronous active-high reset
//   tone_in      : asynchronous tone pin
//   edge_pulse   : one-cycle pulse, 3 cycles after the pin changes
module tone_edge_sync (
   input  logic CLK_50M,
   input  logic RST,
   input  logic tone_in,
   output logic edge_pulse
);
   logic sync_1, sync_2, dly;
   always_ff @(posedge CLK_50M)
      if (RST) {sync_1, sync_2, dly} <= 3'b000;
      else {sync_1, sync_2, dly} <= {tone_in, sync_1, sync_2};
   assign edge_pulse = sync_2 ^ dly;
endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: measures tone half-periods and locks onto one of eight scale notes
//   CLK_50M, RST : 50 MHz clock, synchronous active-high reset
//   bus          : tone_decoder_if.master (TONE_IN in; NOTE, VALID, NOTE_STB out)
//   TONE_DEC_GLITCH_FILTER_EN : when defined, edges closer than GLITCH_CYC to the
//                               previous accepted edge are ignored
module tone_decoder
   import tone_pkg::*;
#(
   parameter int TOL        = 500,
   parameter int LOCK_CNT   = 4,
   parameter int TIMEOUT    = 100000,
   parameter int GLITCH_CYC = 1000
) (
   input logic            CLK_50M,
   input logic            RST,
   tone_decoder_if.master bus
);
`ifdef TONE_DEC_GLITCH_FILTER_EN
   localparam bit GLITCH_EN = 1'b1;
`else
   localparam bit GLITCH_EN = 1'b0;
`endif
   state_e      state;
   note_e       cand, meas_note;
   logic [7:0]  match_cnt, next_cnt, note;
   logic [19:0] cnt;
   logic [20:0] diff;
   logic        edge_pulse, accept, timeout, have_edge, valid, note_stb;
   tone_edge_sync u_edge (
      .CLK_50M    (CLK_50M),
      .RST        (RST),
      .tone_in    (bus.TONE_IN),
      .edge_pulse (edge_pulse)
   );
   // the first edge after idle is always taken, it only opens the measurement
   assign accept   = edge_pulse && (!GLITCH_EN || !have_edge || cnt >= 20'(GLITCH_CYC));
   assign timeout  = cnt == 20'(TIMEOUT) && !accept;
   assign next_cnt = (meas_note == cand) ? match_cnt + 8'd1 : 8'd1;
   // TOL stays under half the smallest table gap, so at most one entry matches
   always_comb begin
      meas_note = NOTE_NONE;
      diff      = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         diff = {1'b0, cnt} - {1'b0, half_period(3'(i))};
         if (diff[20]) diff = -diff;
         if (diff <= 21'(TOL)) meas_note = note_e'(4'(i));
      end
   end
   always_ff @(posedge CLK_50M)
      if (RST) cnt <= '0;
      else if (accept) cnt <= 20'd1;
      else if (cnt != 20'(TIMEOUT)) cnt <= cnt + 20'd1;
   always_ff @(posedge CLK_50M)
      if (RST) begin
         state     <= ST_IDLE;
         cand      <= NOTE_NONE;
         match_cnt <= '0;
         have_edge <= 1'b0;
         note      <= '0;
         valid     <= 1'b0;
         note_stb  <= 1'b0;
      end else begin
         note_stb <= 1'b0;
         if (timeout) begin
            state     <= ST_IDLE;
            have_edge <= 1'b0;
            match_cnt <= '0;
            note      <= '0;
            valid     <= 1'b0;
         end else if (accept)
            case (state)
               ST_IDLE: begin
                  state     <= ST_ACQUIRE;
                  have_edge <= 1'b1;
               end
               ST_ACQUIRE:
                  if (meas_note == NOTE_NONE) match_cnt <= '0;
                  else begin
                     cand      <= meas_note;
                     match_cnt <= next_cnt;
                     if (next_cnt >= 8'(LOCK_CNT)) begin
                        state    <= ST_LOCKED;
                        note     <= note_onehot(meas_note);
                        valid    <= 1'b1;
                        note_stb <= 1'b1;
                     end
                  end
               default:
                  if (meas_note != cand) begin
                     state     <= ST_ACQUIRE;
                     note      <= '0;
                     valid     <= 1'b0;
                     cand      <= meas_note;
                     match_cnt <= (meas_note == NOTE_NONE) ? 8'd0 : 8'd1;
                  end
            endcase
      end
   assign bus.NOTE     = note;
   assign bus.VALID    = valid;
   assign bus.NOTE_STB = note_stb;
endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: randomized scoreboard bench for tone_decoder
module tb_tone_decoder;
   localparam int TOL = 500, LOCK_CNT = 4, TIMEOUT = 100000, GLITCH_CYC = 1000;
   localparam int REF_HP [8] = '{47775, 42569, 37920, 35792, 31889, 28410, 25310, 23890};
   typedef struct {
      int         cyc;
      logic [7:0] note;
   } exp_t;
   logic CLK_50M = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0, tests = 0, fails = 0;
   exp_t q[$];
   bit   mon_en = 1'b0;
   logic [7:0] prev_note = 8'h00;
   bit   m_have = 1'b0;
   int   m_last = 0, m_run_note = -1, m_run_len = 0;
   logic [7:0] m_out = 8'h00;
   tone_decoder_if bus();
   tone_decoder #(.TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .GLITCH_CYC(GLITCH_CYC)) dut (
      .CLK_50M (CLK_50M),
      .RST     (RST),
      .bus     (bus)
   );
   always #10 CLK_50M = ~CLK_50M;
   always @(posedge CLK_50M) cyc <= cyc + 1;
   task automatic chk(input bit ok, input string name, input int act, input int exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic int match_note(input int meas);
      for (int i = 0; i < 8; i++) begin
         int d = meas - REF_HP[i];
         if ((d < 0 ? -d : d) <= TOL) return i;
      end
      return -1;
   endfunction
   task automatic m_set_out(input int at, input logic [7:0] n);
      if (n != m_out) begin
         q.push_back('{at, n});
         m_out = n;
      end
   endtask
   task automatic m_clear();
      m_have     = 1'b0;
      m_run_len  = 0;
      m_run_note = -1;
   endtask
   // reference: locked while the current run of identical valid notes is >= LOCK_CNT
   task automatic model_edge(input int a);
      int gap, n;
      gap = a - m_last;
      if (gap > TIMEOUT) gap = TIMEOUT;
`ifdef TONE_DEC_GLITCH_FILTER_EN
      if (m_have && gap < GLITCH_CYC) return;
`endif
      m_last = a;
      if (!m_have) begin
         m_have = 1'b1;
         return;
      end
      n = match_note(gap);
      if (n < 0) m_run_len = 0;
      else if (n == m_run_note) m_run_len++;
      else m_run_len = 1;
      m_run_note = n;
      m_set_out(a, m_run_len >= LOCK_CNT ? 8'(1 << n) : 8'h00);
   endtask
   task automatic model_tick(input int c);
      if (m_have && c + 3 >= m_last + TIMEOUT) begin
         m_set_out(m_last + TIMEOUT, 8'h00);
         m_clear();
      end
   endtask
   task automatic step(input bit tog);
      @(posedge CLK_50M);
      #1;
      if (tog) begin
         bus.TONE_IN = ~bus.TONE_IN;
         model_edge(cyc + 3);
      end
      model_tick(cyc);
   endtask
   task automatic half(input int p);
      repeat (p - 1) step(1'b0);
      step(1'b1);
   endtask
   function automatic int jit(input int m);
      return int'($urandom_range(0, 2 * m)) - m;
   endfunction
   always @(negedge CLK_50M) begin
      exp_t e;
      if (mon_en) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            chk(1'b0 || q[0].cyc >= cyc, "event_missing", cyc, q[0].cyc);
            void'(q.pop_front());
         end
         if (bus.NOTE !== prev_note || bus.NOTE_STB !== 1'b0) begin
            chk(q.size() > 0, "event_expected", int'(bus.NOTE), int'(prev_note));
            if (q.size() > 0) begin
               e = q.pop_front();
               chk(e.cyc == cyc, "event_time", cyc, e.cyc);
               chk(bus.NOTE === e.note, "note", int'(bus.NOTE), int'(e.note));
               chk(bus.NOTE_STB === (e.note != 8'h00), "note_stb", int'(bus.NOTE_STB), int'(e.note != 8'h00));
               chk(bus.VALID === (e.note != 8'h00), "valid", int'(bus.VALID), int'(e.note != 8'h00));
            end
         end
         prev_note = bus.NOTE;
      end
   end
   initial begin
      int n, w;
      bus.TONE_IN = 1'b0;
      repeat (3) @(posedge CLK_50M);
      #1 RST = 1'b0;
      m_last = cyc + 1;
      @(negedge CLK_50M);
      chk(bus.NOTE === 8'h00, "reset_note", int'(bus.NOTE), 0);
      chk(bus.VALID === 1'b0, "reset_valid", int'(bus.VALID), 0);
      chk(bus.NOTE_STB === 1'b0, "reset_stb", int'(bus.NOTE_STB), 0);
      mon_en = 1'b1;
      repeat (6) half(31889);
      for (int k = 0; k < 6; k++) half(47775 + ((k % 2 == 0) ? 480 : -480));
      repeat (6) half(47775 + 520);
      repeat (6) half(23890 + jit(400));
      repeat (5) half(25310 + jit(400));
      repeat (TIMEOUT + 50) step(1'b0);
      repeat (6) half(35792 + jit(400));
      repeat (6) half(37920);
      repeat (10000) step(1'b0);
      @(posedge CLK_50M);
      #1 RST = 1'b1;
      model_reset(cyc + 1);
      @(posedge CLK_50M);
      #1 RST = 1'b0;
      chk(bus.NOTE === 8'h00, "rst_mid_note", int'(bus.NOTE), 0);
      chk(bus.VALID === 1'b0, "rst_mid_valid", int'(bus.VALID), 0);
      if (bus.TONE_IN) model_edge(cyc + 3);
      model_tick(cyc);
      repeat (6) half(37920);
      repeat (6) half(42569);
      half(300);
      half(200);
      half(42569 - 500);
      repeat (4) half(42569);
      repeat (3) begin
         n = $urandom_range(0, 7);
         repeat ($urandom_range(4, 6)) half(REF_HP[n] + jit(TOL));
      end
      w = 0;
      while (q.size() > 0 && w < 20) begin
         step(1'b0);
         w++;
      end
      @(negedge CLK_50M);
      chk(q.size() == 0, "queue_drained", q.size(), 0);
      chk(bus.VALID === (bus.NOTE != 8'h00), "valid_vs_note", int'(bus.VALID), int'(bus.NOTE != 8'h00));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   task automatic model_reset(input int r);
      m_set_out(r, 8'h00);
      m_clear();
      m_last = r + 1;
   endtask
endmodule
